// File: rtl/regbank_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
// Holds the FSM state encoding and the pointer wrap helper.
package regbank_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int N_REQ_MAX  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Round-robin pointer advance: the slot after the winner, wrapping at n.
  function automatic int ptr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Zero latency; an all-zero req gives an all-zero win.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  always_comb begin
    int idx;
    win     = '0;
    win_idx = '0;
    idx     = 0;
    // Walk from the farthest slot back to ptr so the nearest requester wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx[IDX_W-1:0]]) begin
        win                   = '0;
        win[idx[IDX_W-1:0]]   = 1'b1;
        win_idx               = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter sharing one 1W/2R register bank; write 2 cycles, read 4 cycles.
// Requests stay pending (no backpressure signal) until their one-cycle gnt pulse.
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_wr,
  input  logic [N_REQ*ADDR_W-1:0]    req_dir_a,
  input  logic [N_REQ*ADDR_W-1:0]    req_dir_b,
  input  logic [N_REQ*ADDR_W-1:0]    req_dir_wra,
  input  logic [N_REQ*DATA_W-1:0]    req_di,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rvalid,
  output logic [DATA_W-1:0]          rdata_a,
  output logic [DATA_W-1:0]          rdata_b,
  output logic                       busy,
  output logic [ADDR_W-1:0]          bank_dir_a,
  output logic [ADDR_W-1:0]          bank_dir_b,
  output logic [ADDR_W-1:0]          bank_dir_wra,
  output logic [DATA_W-1:0]          bank_di,
  output logic                       bank_rd,
  output logic                       bank_wr,
  input  logic [DATA_W-1:0]          bank_doa,
  input  logic [DATA_W-1:0]          bank_dob
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] pick_win;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] win_q;
  logic [IDX_W-1:0] ptr_q;
  logic             op_wr_q;
  logic             any_req;

  assign any_req = |req;
  assign busy    = (state != IDLE);

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Strobes decode straight from the state register so an async reset kills them at once.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    rvalid    = '0;
    bank_rd   = 1'b0;
    bank_wr   = 1'b0;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        gnt = win_q;
        if (op_wr_q) begin
          bank_wr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          bank_rd   = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        rvalid    = win_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      op_wr_q      <= 1'b0;
      ptr_q        <= '0;
      bank_dir_a   <= '0;
      bank_dir_b   <= '0;
      bank_dir_wra <= '0;
      bank_di      <= '0;
      rdata_a      <= '0;
      rdata_b      <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        win_q        <= pick_win;
        op_wr_q      <= req_wr[pick_idx];
        ptr_q        <= IDX_W'(ptr_next(int'(pick_idx), N_REQ));
        bank_dir_a   <= req_dir_a[int'(pick_idx)*ADDR_W +: ADDR_W];
        bank_dir_b   <= req_dir_b[int'(pick_idx)*ADDR_W +: ADDR_W];
        bank_dir_wra <= req_dir_wra[int'(pick_idx)*ADDR_W +: ADDR_W];
        bank_di      <= req_di[int'(pick_idx)*DATA_W +: DATA_W];
      end
      // Bank outputs settled on the falling edge inside ISSUE.
      if (state == CAPTURE) begin
        rdata_a <= bank_doa;
        rdata_b <= bank_dob;
      end
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter with four requesters and a behavioural register bank.
// Expected grants/data come from a transaction-level round-robin and memory model.
module tb_regbank_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0, req_wr = '0;
  logic [N*AW-1:0] req_dir_a = '0, req_dir_b = '0, req_dir_wra = '0;
  logic [N*DW-1:0] req_di = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata_a, rdata_b, bank_di, bank_doa, bank_dob;
  logic [AW-1:0]   bank_dir_a, bank_dir_b, bank_dir_wra;
  logic            busy, bank_rd, bank_wr;

  regbank_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
    .req_dir_a(req_dir_a), .req_dir_b(req_dir_b), .req_dir_wra(req_dir_wra), .req_di(req_di),
    .gnt(gnt), .rvalid(rvalid), .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .bank_dir_a(bank_dir_a), .bank_dir_b(bank_dir_b), .bank_dir_wra(bank_dir_wra),
    .bank_di(bank_di), .bank_rd(bank_rd), .bank_wr(bank_wr),
    .bank_doa(bank_doa), .bank_dob(bank_dob)
  );

  // Register bank: write on the rising edge, read on the falling edge.
  logic [DW-1:0] mem [32];
  always @(posedge clk) if (bank_wr) mem[bank_dir_wra] <= bank_di;
  always @(negedge clk) if (bank_rd) begin
    bank_doa <= mem[bank_dir_a];
    bank_dob <= mem[bank_dir_b];
  end

  int n_vec = 0, n_bad = 0, cyc = 0;
  logic [DW-1:0] ref_mem [32];
  int ptr_m, nxt_free, gnt_cyc, gnt_who, rv_cyc, rv_who, wc_cyc;
  bit gnt_wr;
  logic [AW-1:0] wc_a, e_dir_a, e_dir_b, e_dir_wra;
  logic [DW-1:0] wc_d, e_di, rv_a, rv_b, hold_a, hold_b;
  int waits [N];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = v >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic post(input int i, input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] wa, input logic [DW-1:0] d);
    req[IW'(i)]             = 1'b1;
    req_wr[IW'(i)]          = wr;
    req_dir_a[i*AW +: AW]   = a;
    req_dir_b[i*AW +: AW]   = b;
    req_dir_wra[i*AW +: AW] = wa;
    req_di[i*DW +: DW]      = d;
  endtask

  task automatic post_rand(input int i);
    post(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)),
         AW'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic model_reset();
    ptr_m = 0; nxt_free = 0; gnt_cyc = -1; rv_cyc = -1; wc_cyc = -1; cyc = 0;
    hold_a = '0; hold_b = '0; e_dir_a = '0; e_dir_b = '0; e_dir_wra = '0; e_di = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  // One clock: check everything the DUT shows in this cycle against the model.
  task automatic tick();
    logic [N-1:0] eg, er;
    @(negedge clk);
    cyc++;
    if (cyc == wc_cyc) begin ref_mem[wc_a] = wc_d; wc_cyc = -1; end
    if (cyc == rv_cyc) begin hold_a = rv_a; hold_b = rv_b; end
    eg = (cyc == gnt_cyc) ? (N'(1) << gnt_who) : '0;
    er = (cyc == rv_cyc)  ? (N'(1) << rv_who)  : '0;
    check_eq("gnt", gnt, eg);
    check_eq("bank_wr", bank_wr, (cyc == gnt_cyc) && gnt_wr);
    check_eq("bank_rd", bank_rd, (cyc == gnt_cyc) && !gnt_wr);
    check_eq("rvalid", rvalid, er);
    check_eq("rdata_a", rdata_a, hold_a);
    check_eq("rdata_b", rdata_b, hold_b);
    check_eq("bank_dir_a", bank_dir_a, e_dir_a);
    check_eq("bank_dir_b", bank_dir_b, e_dir_b);
    check_eq("bank_dir_wra", bank_dir_wra, e_dir_wra);
    check_eq("bank_di", bank_di, e_di);
    check_eq("busy", busy, cyc < nxt_free);
    if (cyc == gnt_cyc) req[IW'(gnt_who)] = 1'b0;
  endtask

  // Arbiter free and requests pending: decide the winner and schedule its outcome.
  task automatic model();
    int w;
    if (cyc < nxt_free || req == '0) return;
    w = rr_pick(ptr_m, req);
    for (int i = 0; i < N; i++) if (i != w && req[IW'(i)]) waits[i]++;
    check_eq("starve", waits[w] <= N - 1, 1);
    waits[w]  = 0;
    gnt_cyc   = cyc + 1;
    gnt_who   = w;
    gnt_wr    = req_wr[IW'(w)];
    e_dir_a   = req_dir_a[w*AW +: AW];
    e_dir_b   = req_dir_b[w*AW +: AW];
    e_dir_wra = req_dir_wra[w*AW +: AW];
    e_di      = req_di[w*DW +: DW];
    ptr_m     = (w + 1) % N;
    if (gnt_wr) begin
      wc_cyc = cyc + 2; wc_a = e_dir_wra; wc_d = e_di; nxt_free = cyc + 2;
    end else begin
      rv_cyc = cyc + 3; rv_who = w; rv_a = ref_mem[e_dir_a]; rv_b = ref_mem[e_dir_b];
      nxt_free = cyc + 4;
    end
  endtask

  task automatic run(input int maxc);
    bit done = 1'b0;
    for (int k = 0; k < maxc && !done; k++) begin
      tick();
      model();
      done = (req == '0) && (cyc >= nxt_free) && (cyc >= rv_cyc);
    end
    check_eq("drain", done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_bank_rd", bank_rd, 0);
    check_eq("rst_bank_wr", bank_wr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdata_a", rdata_a, 0);
    check_eq("rst_rdata_b", rdata_b, 0);
    check_eq("rst_dir_a", bank_dir_a, 0);
    check_eq("rst_dir_b", bank_dir_b, 0);
    check_eq("rst_dir_wra", bank_dir_wra, 0);
    check_eq("rst_di", bank_di, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] old9, saved3;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = $urandom;
      mem[i] <= ref_mem[i];
    end
    #2;
    do_reset();

    // Write/read hazard in one cycle: requester 0 wins from pointer 0.
    tick(); post(0, 1, 0, 0, 7, 32'hDEADBEEF); post(1, 0, 7, 7, 0, 0); model();
    run(40);
    check_eq("hazard_r7", rdata_a, 32'hDEADBEEF);

    // Single write then read of r4/r5.
    tick(); post(0, 1, 0, 0, 4, 32'h12); model(); run(20);
    tick(); post(0, 0, 4, 5, 0, 0); model(); run(20);
    check_eq("rd_r4", rdata_a, 32'h12);

    // Read data holds across later writes by others.
    saved3 = ref_mem[3];
    tick(); post(2, 0, 3, 0, 0, 0); model(); run(20);
    tick(); post(1, 1, 0, 0, 3, 32'hA5A5A5A5); post(3, 1, 0, 0, 0, 32'h0BAD0BAD); model(); run(20);
    check_eq("hold_r3", rdata_a, saved3);

    // Reset lands during the ISSUE cycle of a write to r9.
    tick(); do_reset();
    old9 = ref_mem[9];
    tick(); post(0, 1, 0, 0, 9, 32'h55); model();
    tick();
    check_eq("abort_issue", bank_wr, 1);
    do_reset();
    tick(); post(1, 0, 9, 9, 0, 0); post(0, 0, 9, 9, 0, 0); model();
    check_eq("first_after_rst", gnt_who, 0);
    run(40);
    check_eq("abort_r9", rdata_a, old9);

    // Contention between requesters 0 and 1, then all four.
    tick(); do_reset();
    for (int c = 0; c < 60; c++) begin
      tick();
      for (int i = 0; i < 2; i++) if (!req[IW'(i)]) post_rand(i);
      model();
    end
    run(40);
    tick(); do_reset();
    for (int c = 0; c < 80; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (!req[IW'(i)]) post_rand(i);
      model();
    end
    run(60);

    // Sparse random traffic.
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (!req[IW'(i)] && $urandom_range(0, 2) == 0) post_rand(i);
      model();
    end
    run(60);

    for (int i = 0; i < 32; i++) check_eq("bank_contents", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Shares the single-write/dual-read 32x32 register bank among `N_REQ` requesters (core pipeline, loader, debug port). Requests are arbitrated round-robin. Each granted request is turned into one bank command: `bank_wr` for writes, `bank_rd` for reads. The block captures read data and returns it to the winner. It sits between the requesters and the bank, and is the only block that drives the bank's control and address pins.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width

- `clk`  in  1  clock, rising-edge active
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  N_REQ  per-requester request; held high with fields stable until `gnt`
- `req_wr`  in  N_REQ  1 = write, 0 = read
- `req_dir_a`  in  N_REQ*ADDR_W  read address A, flattened, requester i at [i*ADDR_W +: ADDR_W]
- `req_dir_b`  in  N_REQ*ADDR_W  read address B, flattened
- `req_dir_wra`  in  N_REQ*ADDR_W  write address, flattened
- `req_di`  in  N_REQ*DATA_W  write data, flattened
- `gnt`  out  N_REQ  one-cycle one-hot pulse: request consumed
- `rvalid`  out  N_REQ  one-cycle one-hot pulse: `rdata_a`/`rdata_b` valid for that requester
- `rdata_a`, `rdata_b`  out  DATA_W  captured read data; held until next read capture
- `busy`  out  1  high in any state other than IDLE
- `bank_dir_a`, `bank_dir_b`, `bank_dir_wra`  out  ADDR_W  bank addresses
- `bank_di`  out  DATA_W  bank write data
- `bank_rd`, `bank_wr`  out  1  bank read/write strobes

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - If any `req` is high, pick the winner with the round-robin picker.
  - Register the winner's fields into the `bank_*` address/data outputs.
  - Go to ISSUE.
- **ISSUE**
  - Assert `gnt[winner]`.
  - Assert `bank_wr` if the request is a write, else `bank_rd`; exactly one strobe is high.
  - Write: next state IDLE. Read: next state CAPTURE.
- **CAPTURE**
  - Sample bank `doa`/`dob` into `rdata_a`/`rdata_b`. The bank read completes on the falling edge inside ISSUE.
  - Go to RESP.
- **RESP**
  - Assert `rvalid[winner]`.
  - Go to IDLE.
- Round-robin pointer: after each grant, the pointer moves to winner+1 mod N_REQ. The search starts at the pointer. No starvation: each requester waits at most N_REQ-1 other grants.
- Addresses pass through unchanged, including address 0; r0 is not special-cased.
- Ordering follows grant order. A write granted before a read to the same address is visible to that read.
- `bank_*` address/data outputs hold their last value between commands.

## Timing
- **Reset values:**
  - state IDLE; pointer 0
  - `gnt`, `rvalid`, `bank_rd`, `bank_wr`, `busy` all 0
  - `rdata_a`, `rdata_b`, `bank_dir_*`, `bank_di` all 0
- **Write latency:** `req` high in cycle T (IDLE) -> `gnt` and `bank_wr` in T+1 -> bank updated at the T+2 rising edge. Throughput: one write per 2 cycles.
- **Read latency:** `req` in T -> `gnt`/`bank_rd` in T+1 -> capture in T+2 -> `rvalid` and data in T+3. Throughput: one read per 4 cycles.
- **Requester behaviour:** the requester may drop or change `req` in the cycle after `gnt`. A `req` deasserted before `gnt` is a protocol violation; behaviour is undefined.
- **Simultaneous requests:** only one winner per IDLE. The others keep waiting, with no lost requests.
- **Back-to-back:** IDLE with `req` pending always issues; there are no idle bubbles beyond the FSM states.
- **Reset mid-operation:** all strobes drop immediately (async). No `gnt` or `rvalid` is issued for the aborted command. A write whose ISSUE cycle is cut before the rising edge is not performed.

## Structure
- Package `regbank_arb_pkg`:
  - state enum (IDLE, ISSUE, CAPTURE, RESP)
  - defaults for `ADDR_W`, `DATA_W`, `N_REQ_MAX`
- Sub-module `rr_picker`: combinational; inputs `req` and `ptr`; outputs one-hot `win` and `win_idx`.
- Top level: FSM, winner/op registers, pointer register, read-data capture registers.

## Test plan
- **Single write then read:** write requester 0 r4 = 0x12, then read r4/r5 -> `bank_wr` in cycle 2. Read `rvalid[0]` arrives 3 cycles after `req`, with `rdata_a`=0x12 and `rdata_b` = r5 contents.
- **Contention:** both requesters request continuously from reset -> grants alternate 0,1,0,1. Each `gnt` is one-hot, and no cycle has `bank_rd` and `bank_wr` both high.
- **Write/read hazard:** requester 0 writes r7=0xDEADBEEF while requester 1 reads r7 in the same cycle -> requester 0 wins (pointer 0), and requester 1 gets `rdata_a`=0xDEADBEEF.
- **Data hold:** read r3, then two writes by another requester -> `rdata_a` unchanged until the next read capture.
- **Reset abort:** `rst_n` low during ISSUE of a write to r9=0x55 -> r9 unchanged; all outputs return to reset values asynchronously; the first grant after reset goes to requester 0.
- **N_REQ=4, all requesting:** grants follow order 0,1,2,3,0. No requester waits more than 3 grants.
